// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - I2S master clock generator: fractional mclk, sclk and ws
// Configuration written while running is held in a shadow and applied at the ws 1->0 frame boundary.
module i2s_clk_gen #(
  parameter int DIV_W     = 8,
  parameter int FRAC_W    = 4,
  parameter int BITS_W    = 6,
  parameter int RST_DIV_I = 4,
  parameter int RST_DIV_F = 0,
  parameter int RST_SH    = 1,
  parameter int RST_BITS  = 16
) (
  input  logic              pclk,
  input  logic              rst_,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [FRAC_W-1:0] cfg_div_f,
  input  logic [1:0]        cfg_sh,
  input  logic [BITS_W-1:0] cfg_bits,
  output logic              cfg_ack,
  output logic              mclk,
  output logic              sclk,
  output logic              ws,
  output logic              sclk_rise,
  output logic              sclk_fall,
  output logic              frame_start,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
  localparam logic [BITS_W-1:0] BITS_MIN = BITS_W'(2);
  localparam logic [BITS_W-1:0] BITS_ONE = BITS_W'(1);

  state_t            state;
  logic [DIV_W-1:0]  act_div_i, shd_div_i, use_div_i, use_div_eff;
  logic [FRAC_W-1:0] act_div_f, shd_div_f, use_div_f, acc, acc_base, acc_sum;
  logic [1:0]        act_sh, shd_sh, use_sh;
  logic [BITS_W-1:0] act_bits, shd_bits, use_bits, bits_eff, bits_last, bcnt;
  logic [DIV_W:0]    per, mcnt, mcnt_inc, per_new;
  logic [2:0]        scnt;
  logic [3:0]        sh_max;
  logic              pend, carry, running;
  logic              pstart_run, sclk_tog, sfall, ws_tog, boundary;
  logic              apply_in, apply_sh, apply, go_idle;

  assign busy       = (state != IDLE);
  assign running    = (state != IDLE);
  assign mcnt_inc   = mcnt + 1'b1;
  assign pstart_run = running && (mcnt_inc == per);
  assign sh_max     = (4'd1 << act_sh) - 4'd1;
  assign bits_eff   = (act_bits < BITS_MIN) ? BITS_MIN : act_bits;
  assign bits_last  = bits_eff - BITS_ONE;

  // sclk and ws only ever change on an mclk period start
  assign sclk_tog = pstart_run && ({1'b0, scnt} == sh_max);
  assign sfall    = sclk_tog && sclk;
  assign ws_tog   = sfall && (bcnt == bits_last);
  assign boundary = ws_tog && ws;
  assign go_idle  = (state == DRAIN) && !en && boundary;

  assign apply_in = cfg_load && ((state == IDLE) || boundary);
  assign apply_sh = !cfg_load && pend && boundary;
  assign apply    = apply_in || apply_sh;

  always_comb begin
    use_div_i = act_div_i;
    use_div_f = act_div_f;
    use_sh    = act_sh;
    use_bits  = act_bits;
    if (apply_in) begin
      use_div_i = cfg_div_i;
      use_div_f = cfg_div_f;
      use_sh    = cfg_sh;
      use_bits  = cfg_bits;
    end else if (apply_sh) begin
      use_div_i = shd_div_i;
      use_div_f = shd_div_f;
      use_sh    = shd_sh;
      use_bits  = shd_bits;
    end
  end

  // A freshly applied configuration restarts the fractional accumulator from zero
  assign use_div_eff      = (use_div_i < DIV_MIN) ? DIV_MIN : use_div_i;
  assign acc_base         = apply ? '0 : acc;
  assign {carry, acc_sum} = {1'b0, acc_base} + {1'b0, use_div_f};
  assign per_new          = {1'b0, use_div_eff} + {{DIV_W{1'b0}}, carry};

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      state       <= IDLE;
      mclk        <= 1'b0;
      sclk        <= 1'b0;
      ws          <= 1'b0;
      sclk_rise   <= 1'b0;
      sclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      cfg_ack     <= 1'b0;
      per         <= '0;
      mcnt        <= '0;
      scnt        <= '0;
      bcnt        <= '0;
      acc         <= '0;
      pend        <= 1'b0;
      act_div_i   <= DIV_W'(RST_DIV_I);
      act_div_f   <= FRAC_W'(RST_DIV_F);
      act_sh      <= 2'(RST_SH);
      act_bits    <= BITS_W'(RST_BITS);
      shd_div_i   <= '0;
      shd_div_f   <= '0;
      shd_sh      <= '0;
      shd_bits    <= '0;
    end else begin
      cfg_ack <= apply;
      if (apply) begin
        act_div_i <= use_div_i;
        act_div_f <= use_div_f;
        act_sh    <= use_sh;
        act_bits  <= use_bits;
      end
      if (cfg_load && running && !boundary) begin
        shd_div_i <= cfg_div_i;
        shd_div_f <= cfg_div_f;
        shd_sh    <= cfg_sh;
        shd_bits  <= cfg_bits;
        pend      <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          sclk        <= 1'b0;
          ws          <= 1'b0;
          sclk_rise   <= 1'b0;
          sclk_fall   <= 1'b0;
          frame_start <= 1'b0;
          scnt        <= '0;
          bcnt        <= '0;
          mcnt        <= '0;
          if (en) begin
            state <= RUN;
            acc   <= acc_sum;
            per   <= per_new;
            mclk  <= 1'b1;
          end else begin
            acc  <= '0;
            per  <= '0;
            mclk <= 1'b0;
          end
        end
        default: begin
          if (en)           state <= RUN;
          else if (go_idle) state <= IDLE;
          else              state <= DRAIN;

          if (go_idle) begin
            mclk        <= 1'b0;
            sclk        <= 1'b0;
            ws          <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            per         <= '0;
            mcnt        <= '0;
            scnt        <= '0;
            bcnt        <= '0;
            acc         <= '0;
          end else begin
            sclk_rise   <= sclk_tog && !sclk;
            sclk_fall   <= sfall;
            frame_start <= boundary;
            if (pstart_run) begin
              acc  <= acc_sum;
              per  <= per_new;
              mcnt <= '0;
              mclk <= 1'b1;
              if (sclk_tog) begin
                sclk <= ~sclk;
                scnt <= '0;
              end else begin
                scnt <= scnt + 1'b1;
              end
              if (sfall) begin
                if (ws_tog) begin
                  ws   <= ~ws;
                  bcnt <= '0;
                end else begin
                  bcnt <= bcnt + 1'b1;
                end
              end
            end else begin
              mcnt <= mcnt_inc;
              mclk <= (mcnt_inc < (per >> 1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/i2s_clk_gen.md
I2S_CLK_GEN -- requirements
Module: i2s_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the integer mclk divisor.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional mclk divisor.
REQ-003 SHALL have parameter BITS_W, default 6: width of the bits-per-channel field.
REQ-004 SHALL have parameter RST_DIV_I, default 4; RST_DIV_F, default 0; RST_SH, default 1; RST_BITS, default 16: reset values of the active configuration.
REQ-005 pclk  in  1  sole clock; all logic on posedge pclk.
REQ-006 rst_  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  run request.
REQ-008 cfg_load  in  1  one-cycle strobe to capture the cfg_* inputs.
REQ-009 cfg_div_i  in  DIV_W  integer part of the mclk period, in pclk cycles.
REQ-010 cfg_div_f  in  FRAC_W  fractional part of the mclk period, in units of 1/2^FRAC_W.
REQ-011 cfg_sh  in  2  sclk divisor select: sclk period = 2^(cfg_sh+1) mclk periods.
REQ-012 cfg_bits  in  BITS_W  sclk periods per channel (ws half-period).
REQ-013 cfg_ack  out  1  one-cycle pulse when captured configuration becomes active.
REQ-014 mclk, sclk, ws  out  1 each  registered clock outputs.
REQ-015 sclk_rise, sclk_fall  out  1 each  one-cycle strobes, high in the first cycle after sclk changes 0->1 and 1->0 respectively.
REQ-016 frame_start  out  1  one-cycle strobe, high in the first cycle after ws changes 1->0.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, RUN and DRAIN; IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE at the next frame boundary (the ws 1->0 toggle point).
REQ-019 In IDLE, mclk, sclk, ws and all strobes SHALL be 0, and all counters and the fractional accumulator SHALL be 0.
REQ-020 In the first RUN cycle after IDLE, mclk SHALL be 1; sclk and ws SHALL be 0.
REQ-021 Each mclk period P SHALL start with acc' = acc + div_f (FRAC_W bits), with P = div_i + carry-out of that add.
REQ-022 mclk SHALL be high for floor(P/2) cycles and low for the remainder (e.g. P=5: 2 high, 3 low).
REQ-023 An active div_i below 2 SHALL be treated as 2.
REQ-024 sclk SHALL toggle on every 2^cfg_sh-th mclk period start, starting low.
REQ-025 ws SHALL toggle coincident with every bits-th sclk falling edge; an active bits value below 2 SHALL be treated as 2.
REQ-026 cfg_load while IDLE SHALL copy the cfg_* inputs into the active registers on the next edge, with cfg_ack pulsed in that same cycle.
REQ-027 cfg_load while RUN or DRAIN SHALL capture the cfg_* inputs into shadow registers; those registers SHALL be applied at the next frame boundary, with cfg_ack pulsed there and the accumulator cleared.
REQ-028 Repeated cfg_load before application SHALL overwrite the shadow (last write wins) and SHALL produce a single cfg_ack.
REQ-029 Configuration changes SHALL never produce an mclk or sclk pulse shorter than the shorter of the old and new half-periods.
REQ-030 en=0 in RUN SHALL complete the current frame; at the boundary, outputs SHALL go to 0 and busy SHALL drop in the same cycle.
REQ-031 A DRAIN->IDLE transition with a pending shadow SHALL still apply it and pulse cfg_ack.
REQ-032 Simultaneous cfg_load and frame boundary SHALL apply the new inputs immediately; this counts as the single ack.

Reset
REQ-033 rst_=0 SHALL asynchronously force IDLE and drive all outputs to 0.
REQ-034 rst_=0 SHALL clear all counters, the accumulator and the pending flag.
REQ-035 rst_=0 SHALL load the active configuration with RST_DIV_I, RST_DIV_F, RST_SH and RST_BITS.
REQ-036 Reset asserted mid-frame SHALL take effect without waiting for a frame boundary.

Verification
REQ-037 div_i=4, f=0, sh=0, bits=16, en=1 -> mclk 2 high/2 low; sclk period 8; ws period 256 pclk; frame_start every 256 cycles.
REQ-038 div_i=3, f=8 -> mclk periods alternate 3,4 (first period 3); 32 mclk periods take exactly 112 pclk.
REQ-039 Running with div_i=4; cfg_load div_i=6 mid-frame -> no cfg_ack until frame_start; cfg_ack coincides with it; periods are 6 thereafter; no short pulse.
REQ-040 en dropped at bit 5 of the left channel -> outputs continue to the end of the right channel, then all 0 and busy=0 at the boundary cycle.
REQ-041 div_i=1, div_f=0 -> mclk period 2; div_i=5 -> 2 high/3 low.
REQ-042 rst_ pulsed low mid-frame -> outputs 0 immediately; after release with en=1, default timing resumes (mclk period 4, sclk period 16).
